// File: rtl/dbram_pkg.sv
// Shared definitions for the data-BRAM arbiter slice.
//   ADDR_W / DATA_W / BE_W : default geometry of the data BRAM (2048 x 32, 4 byte lanes)
//   port_e                 : requester identity (LSU = port 0, debug/loader = port 1)
//   dbram_req_t            : one requester's command bundle
//   arb_grant()            : two-requester arbiter used for both the read and write ports
package dbram_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    PORT_LSU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   wmask;
    logic [DATA_W-1:0] wdata;
  } dbram_req_t;

  // One-hot grant for two requesters. On a conflict the pointer picks the
  // winner when round-robin is enabled, otherwise the LSU always wins.
  function automatic logic [1:0] arb_grant(input logic [1:0] req,
                                           input port_e      ptr,
                                           input logic       rr_en);
    logic [1:0] gnt;
    gnt = req;
    if (req == 2'b11) begin
      if (rr_en && (ptr == PORT_DBG)) gnt = 2'b10;
      else                            gnt = 2'b01;
    end
    return gnt;
  endfunction

endpackage

// File: rtl/dbraminst.sv
// Byte-writable simple dual-port data BRAM (one read port, one write port).
//   clk      : clock
//   rd_en    : read enable; rd_data updates one cycle later, holds otherwise
//   rd_addr  : read word address
//   rd_data  : registered read data (old contents on a same-cycle write to the same word)
//   wr_en    : per-byte write enables
//   wr_addr  : write word address
//   wr_data  : write data
module dbraminst #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  input  logic [DATA_W/8-1:0]   wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (rd_en) rd_q <= mem_q[rd_addr];
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (wr_en[b]) mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/dbram_arbiter.sv
// Two-requester arbiter in front of one data BRAM.
//   clk, rst   : clock; synchronous active-high reset
//   req_valid  : per-port request valid
//   req_ready  : per-port accept (combinational, low during reset)
//   req_we     : 1 = write, 0 = read
//   req_addr   : word address
//   req_wmask  : byte enables (writes only)
//   req_wdata  : write data
//   rsp_valid  : read data valid, exactly one cycle after the read was accepted
//   rsp_data   : read data, write-first with respect to same-cycle writes;
//                holds its last value while rsp_valid is low
// Read and write ports are arbitrated independently, each with its own
// round-robin pointer, so a read and a write from different ports both go.
module dbram_arbiter #(
  parameter int RR_EN  = 1,
  parameter int ADDR_W = dbram_pkg::ADDR_W,
  parameter int DATA_W = dbram_pkg::DATA_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    req_valid,
  output logic [1:0]                    req_ready,
  input  logic [1:0]                    req_we,
  input  logic [1:0][ADDR_W-1:0]        req_addr,
  input  logic [1:0][DATA_W/8-1:0]      req_wmask,
  input  logic [1:0][DATA_W-1:0]        req_wdata,
  output logic [1:0]                    rsp_valid,
  output logic [1:0][DATA_W-1:0]        rsp_data
);

  import dbram_pkg::*;

  localparam int   LANES = DATA_W / 8;
  localparam logic RR_ON = (RR_EN != 0);

  logic [1:0]        rd_req, wr_req, rd_gnt, wr_gnt;
  port_e             rd_sel, wr_sel;
  port_e             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic              ram_rd_en;
  logic [LANES-1:0]  ram_wr_en;
  logic [DATA_W-1:0] ram_rd_data;

  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              byp_hit_q, byp_hit_d;
  logic [LANES-1:0]  byp_mask_q, byp_mask_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic [DATA_W-1:0] merged;
  logic [1:0][DATA_W-1:0] hold_q, hold_d;

  // Request decode and arbitration
  always_comb begin
    rd_req    = rst ? 2'b00 : (req_valid & ~req_we);
    wr_req    = rst ? 2'b00 : (req_valid &  req_we);
    rd_gnt    = arb_grant(rd_req, rd_ptr_q, RR_ON);
    wr_gnt    = arb_grant(wr_req, wr_ptr_q, RR_ON);
    rd_sel    = rd_gnt[1] ? PORT_DBG : PORT_LSU;
    wr_sel    = wr_gnt[1] ? PORT_DBG : PORT_LSU;
    req_ready = rd_gnt | wr_gnt;

    // After a conflict the pointer moves to the requester that lost.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (&rd_req) rd_ptr_d = rd_gnt[0] ? PORT_DBG : PORT_LSU;
    if (&wr_req) wr_ptr_d = wr_gnt[0] ? PORT_DBG : PORT_LSU;

    ram_rd_en = |rd_gnt;
    ram_wr_en = (|wr_gnt) ? req_wmask[wr_sel] : '0;

    rsp_valid_d = rd_gnt;
    byp_hit_d   = ram_rd_en & (|wr_gnt) & (req_addr[rd_sel] == req_addr[wr_sel]);
    byp_mask_d  = req_wmask[wr_sel];
    byp_data_d  = req_wdata[wr_sel];
  end

  dbraminst #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_addr (req_addr[rd_sel]),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_addr (req_addr[wr_sel]),
    .wr_data (req_wdata[wr_sel])
  );

  // The RAM returns the pre-write word on a same-cycle hit; overlay the
  // bytes that write carried so the response is write-first.
  always_comb begin
    merged = ram_rd_data;
    for (int unsigned b = 0; b < LANES; b++) begin
      if (byp_hit_q && byp_mask_q[b]) merged[b*8 +: 8] = byp_data_q[b*8 +: 8];
    end
  end

  // A response pending across the edge into reset is dropped while rst is high.
  // rsp_data shows the live merged word in the response cycle and the
  // last delivered word otherwise.
  always_comb begin
    rsp_valid = rsp_valid_q & {2{~rst}};
    hold_d    = hold_q;
    rsp_data  = hold_q;
    for (int unsigned p = 0; p < 2; p++) begin
      if (rsp_valid[p]) begin
        hold_d[p]   = merged;
        rsp_data[p] = merged;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= PORT_LSU;
      wr_ptr_q    <= PORT_LSU;
      rsp_valid_q <= '0;
      byp_hit_q   <= 1'b0;
      byp_mask_q  <= '0;
      byp_data_q  <= '0;
      hold_q      <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      byp_hit_q   <= byp_hit_d;
      byp_mask_q  <= byp_mask_d;
      byp_data_q  <= byp_data_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_dbram_arbiter.sv
// Bench for dbram_arbiter: one round-robin instance and one fixed-priority
// instance, each followed by a word/byte level reference model.
module tb_dbram_arbiter;

  logic clk;
  logic rst;

  logic [1:0]       v  [2];
  logic [1:0]       we [2];
  logic [1:0][10:0] ad [2];
  logic [1:0][3:0]  mk [2];
  logic [1:0][31:0] wd [2];

  logic [1:0]       rdy0, rdy1, rv0, rv1;
  logic [1:0][31:0] rdd0, rdd1;

  dbram_arbiter #(.RR_EN(1), .ADDR_W(11), .DATA_W(32)) dut_rr (
    .clk(clk), .rst(rst), .req_valid(v[0]), .req_ready(rdy0), .req_we(we[0]),
    .req_addr(ad[0]), .req_wmask(mk[0]), .req_wdata(wd[0]),
    .rsp_valid(rv0), .rsp_data(rdd0));

  dbram_arbiter #(.RR_EN(0), .ADDR_W(11), .DATA_W(32)) dut_fx (
    .clk(clk), .rst(rst), .req_valid(v[1]), .req_ready(rdy1), .req_we(we[1]),
    .req_addr(ad[1]), .req_wmask(mk[1]), .req_wdata(wd[1]),
    .rsp_valid(rv1), .rsp_data(rdd1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state per DUT: memory image with per-byte "known" flags,
  // last-loser pointers, and the response due in the next cycle.
  logic [31:0] mem   [2][2048];
  logic [3:0]  km    [2][2048];
  int          ptr_rd[2], ptr_wr[2], nrd[2], nwr[2];
  int          rr_of [2];
  logic [1:0]  pend_v[2];
  logic [31:0] pend_d[2][2];
  logic [3:0]  pend_k[2][2];
  logic [1:0]  g_rd[2], g_wr[2], acc[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic arb(input logic [1:0] req, input int rr_en, input int ptr,
                     output logic [1:0] g, output int nptr);
    int w;
    nptr = ptr;
    g    = req;
    if (req == 2'b11) begin
      w    = (rr_en != 0) ? ptr : 0;
      g    = (w == 1) ? 2'b10 : 2'b01;
      nptr = 1 - w;
    end
  endtask

  task automatic setp(input int d, input int p, input logic vv, input logic w,
                      input logic [10:0] a, input logic [3:0] m, input logic [31:0] x);
    v[d][p] = vv; we[d][p] = w; ad[d][p] = a; mk[d][p] = m; wd[d][p] = x;
  endtask

  task automatic idle(input int d);
    setp(d, 0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    setp(d, 1, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
  endtask

  // Called just after a negedge with inputs applied; returns at the next negedge.
  task automatic step();
    logic [1:0]       rdy_s[2], rv_s[2];
    logic [1:0][31:0] rd_s[2];
    logic [1:0]       rq, wq;
    logic [3:0]       k;
    logic [31:0]      bm;
    logic [10:0]      a;
    #1;
    rdy_s[0] = rdy0; rdy_s[1] = rdy1;
    rv_s[0]  = rv0;  rv_s[1]  = rv1;
    rd_s[0]  = rdd0; rd_s[1]  = rdd1;
    for (int d = 0; d < 2; d++) begin
      rq = rst ? 2'b00 : (v[d] & ~we[d]);
      wq = rst ? 2'b00 : (v[d] & we[d]);
      arb(rq, rr_of[d], ptr_rd[d], g_rd[d], nrd[d]);
      arb(wq, rr_of[d], ptr_wr[d], g_wr[d], nwr[d]);
      acc[d] = g_rd[d] | g_wr[d];
      chk($sformatf("d%0d req_ready", d), 32'(rdy_s[d]), 32'(acc[d]));
      chk($sformatf("d%0d rsp_valid", d), 32'(rv_s[d]), rst ? 32'd0 : 32'(pend_v[d]));
      for (int p = 0; p < 2; p++) begin
        k = pend_k[d][p];
        if (!rst && pend_v[d][p] && k != 4'h0) begin
          bm = {{8{k[3]}}, {8{k[2]}}, {8{k[1]}}, {8{k[0]}}};
          chk($sformatf("d%0d rsp_data[%0d]", d, p), rd_s[d][p] & bm, pend_d[d][p] & bm);
        end
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        ptr_rd[d] = 0; ptr_wr[d] = 0; pend_v[d] = 2'b00;
      end else begin
        for (int p = 0; p < 2; p++) begin
          if (g_wr[d][p]) begin
            a = ad[d][p];
            for (int b = 0; b < 4; b++)
              if (mk[d][p][b]) mem[d][a][b*8 +: 8] = wd[d][p][b*8 +: 8];
            km[d][a] = km[d][a] | mk[d][p];
          end
        end
        pend_v[d] = g_rd[d];
        for (int p = 0; p < 2; p++) begin
          if (g_rd[d][p]) begin
            pend_d[d][p] = mem[d][ad[d][p]];
            pend_k[d][p] = km[d][ad[d][p]];
          end
        end
        ptr_rd[d] = nrd[d];
        ptr_wr[d] = nwr[d];
      end
    end
    @(negedge clk);
  endtask

  logic [1:0]  exp_g;
  logic [31:0] exp_w;
  int          sel;

  initial begin
    rr_of[0] = 1; rr_of[1] = 0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 2048; i++) begin mem[d][i] = '0; km[d][i] = '0; end
      ptr_rd[d] = 0; ptr_wr[d] = 0; pend_v[d] = 2'b00; acc[d] = 2'b00;
      for (int p = 0; p < 2; p++) begin pend_d[d][p] = '0; pend_k[d][p] = '0; end
      idle(d);
    end
    rst = 1'b1;
    @(negedge clk);

    // Reset held with both ports requesting
    for (int d = 0; d < 2; d++) begin
      setp(d, 0, 1'b1, 1'b1, 11'h040, 4'hF, 32'h99999999);
      setp(d, 1, 1'b1, 1'b0, 11'h040, 4'h0, 32'h0);
    end
    repeat (3) begin
      step();
      chk("rst rsp_data0", rdd0[0], 32'h0);
      chk("rst rsp_data1", rdd0[1], 32'h0);
    end
    rst = 1'b0;
    // First conflict after release goes to port 0 on both instances
    for (int d = 0; d < 2; d++) begin
      setp(d, 0, 1'b1, 1'b1, 11'h040, 4'hF, 32'h01020304);
      setp(d, 1, 1'b1, 1'b1, 11'h041, 4'hF, 32'h0A0B0C0D);
    end
    #1;
    chk("post-rst grant rr", 32'(rdy0), 32'h1);
    chk("post-rst grant fx", 32'(rdy1), 32'h1);
    chk("post-rst rsp_data", rdd0[0], 32'h0);
    step();
    for (int d = 0; d < 2; d++) setp(d, 0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    step();
    // Writes presented during reset must not land
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      setp(d, 0, 1'b1, 1'b1, 11'h040, 4'hF, 32'hFFFFFFFF);
      setp(d, 1, 1'b1, 1'b1, 11'h041, 4'hF, 32'h00000000);
    end
    repeat (3) step();
    rst = 1'b0;
    idle(1);
    setp(0, 0, 1'b1, 1'b0, 11'h040, 4'h0, 32'h0);
    setp(0, 1, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    step();
    chk("no write in rst", rdd0[0], 32'h01020304);
    setp(0, 0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    setp(0, 1, 1'b1, 1'b0, 11'h041, 4'h0, 32'h0);
    step();
    chk("no write in rst p1", rdd0[1], 32'h0A0B0C0D);

    // Disjoint write + read of the same word, full forward
    setp(0, 0, 1'b1, 1'b1, 11'h010, 4'hF, 32'hDEADBEEF);
    setp(0, 1, 1'b1, 1'b0, 11'h010, 4'h0, 32'h0);
    #1 chk("disjoint ready", 32'(rdy0), 32'h3);
    step();
    chk("disjoint rsp_valid", 32'(rv0), 32'h2);
    chk("disjoint fwd", rdd0[1], 32'hDEADBEEF);

    // Partial forward
    setp(0, 0, 1'b1, 1'b1, 11'h005, 4'hF, 32'h11223344);
    setp(0, 1, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    step();
    setp(0, 0, 1'b1, 1'b1, 11'h005, 4'b0101, 32'hAABBCCDD);
    setp(0, 1, 1'b1, 1'b0, 11'h005, 4'h0, 32'h0);
    step();
    chk("partial fwd", rdd0[1], 32'h11BB33DD);
    setp(0, 0, 1'b1, 1'b0, 11'h005, 4'h0, 32'h0);
    setp(0, 1, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    step();
    chk("partial later read", rdd0[0], 32'h11BB33DD);

    // Read conflict with round-robin: alternate p0, p1, p0, p1
    setp(0, 0, 1'b1, 1'b1, 11'h001, 4'hF, 32'h00000111);
    step();
    setp(0, 0, 1'b1, 1'b1, 11'h002, 4'hF, 32'h00000222);
    step();
    setp(0, 0, 1'b1, 1'b0, 11'h001, 4'h0, 32'h0);
    setp(0, 1, 1'b1, 1'b0, 11'h002, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk($sformatf("rr grant %0d", i), 32'(rdy0), 32'(exp_g));
      step();
      chk($sformatf("rr rsp owner %0d", i), 32'(rv0), 32'(exp_g));
      chk($sformatf("rr rsp data %0d", i), exp_g[0] ? rdd0[0] : rdd0[1],
          exp_g[0] ? 32'h00000111 : 32'h00000222);
    end
    idle(0);
    step();

    // Write conflict with fixed priority: p0 wins while it keeps asking
    setp(1, 1, 1'b1, 1'b1, 11'h3FF, 4'h0, 32'h55555555);
    for (int i = 0; i < 3; i++) begin
      exp_w = 32'hA0000001 + 32'(i);
      setp(1, 0, 1'b1, 1'b1, 11'h3FF, 4'hF, exp_w);
      #1 chk($sformatf("fx grant %0d", i), 32'(rdy1), 32'h1);
      step();
    end
    setp(1, 0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    #1 chk("fx p1 after p0 drops", 32'(rdy1), 32'h2);
    step();
    setp(1, 0, 1'b1, 1'b0, 11'h3FF, 4'h0, 32'h0);
    setp(1, 1, 1'b1, 1'b0, 11'h3FF, 4'h0, 32'h0);
    #1 chk("fx read conflict", 32'(rdy1), 32'h1);
    step();
    chk("fx final word", rdd1[0], 32'hA0000003);
    setp(1, 0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    step();
    idle(1);

    // Reset right after an accepted read
    setp(0, 0, 1'b1, 1'b1, 11'h030, 4'hF, 32'hCAFEF00D);
    setp(0, 1, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    step();
    setp(0, 0, 1'b1, 1'b0, 11'h030, 4'h0, 32'h0);
    setp(0, 1, 1'b1, 1'b1, 11'h031, 4'hF, 32'h12345678);
    step();
    idle(0);
    rst = 1'b1;
    #1 chk("rsp suppressed by rst", 32'(rv0), 32'h0);
    step();
    step();
    rst = 1'b0;
    setp(0, 0, 1'b1, 1'b0, 11'h030, 4'h0, 32'h0);
    setp(0, 1, 1'b1, 1'b0, 11'h031, 4'h0, 32'h0);
    #1 chk("ptr cleared by rst", 32'(rdy0), 32'h1);
    step();
    chk("read after rst p0", rdd0[0], 32'hCAFEF00D);
    setp(0, 0, 1'b0, 1'b0, 11'h0, 4'h0, 32'h0);
    step();
    chk("write before rst kept", rdd0[1], 32'h12345678);

    // Randomized traffic; a port not accepted keeps its request unchanged
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (!(v[d][p] && !acc[d][p])) begin
            sel = $urandom_range(0, 9);
            setp(d, p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 (sel == 0) ? 11'h000 : (sel == 1) ? 11'h7FF : 11'(11'h100 + $urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), $urandom);
          end
        end
      end
      step();
    end

    rst = 1'b0;
    idle(0);
    idle(1);
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
